// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave front end for a byte-wide memory. The SPI serial clock is clk
// itself; SS_n frames each transaction and MOSI/MISO carry data MSB first.
// A frame is one command bit sampled in CHK_CMD, then ADDR_SIZE+1 further
// bits. Bit 9 = 0 is a write; bit 9 = 1 is a read address, or read data
// when a read address is already pending. A read-data frame then waits for
// tx_valid and shifts the returned byte out on MISO.
//
// Optional feature (macro SPI_SLAVE_CMD_CHECK_EN): check the received
// command bits against the state that received them. A mismatching frame is
// dropped and the sticky cmd_err flag is set until reset. In the default
// build every complete frame is forwarded and cmd_err is tied to 0.
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 cmd_err
);

    localparam int CNT_W = $clog2(ADDR_SIZE + 2);

    // Last counter value of the post-command receive shift and of MISO shift-out.
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(ADDR_SIZE);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Progress inside a WRITE/READ_ADD/READ_DATA frame.
    typedef enum logic [2:0] {
        PH_SHIFT = 3'd0,   // receiving bits ADDR_SIZE..0
        PH_VALID = 3'd1,   // word complete: publish it this edge
        PH_WAIT  = 3'd2,   // read data: waiting for tx_valid
        PH_TX    = 3'd3,   // read data: shifting the byte out on MISO
        PH_DONE  = 3'd4    // nothing left to do until SS_n rises
    } phase_t;

    state_t               r_state;
    phase_t               r_phase;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_SIZE+1:0] r_shift;
    logic [ADDR_SIZE-1:0] r_tx_shift;
    logic [ADDR_SIZE+1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rd_flag;
    logic                 r_miso;
    logic                 w_cmd_ok;

`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic                 r_cmd_err;

    // Command bits must agree with the state the frame was decoded into.
    always_comb begin
        // NOTE: default first so every path assigns w_cmd_ok and no latch is inferred.
        w_cmd_ok = 1'b1;
        case (r_state)
            WRITE:     w_cmd_ok = (r_shift[ADDR_SIZE+1] == 1'b0);
            READ_ADD:  w_cmd_ok = (r_shift[ADDR_SIZE+1:ADDR_SIZE] == 2'b10);
            READ_DATA: w_cmd_ok = (r_shift[ADDR_SIZE+1:ADDR_SIZE] == 2'b11);
            default:   w_cmd_ok = 1'b1;
        endcase
    end

    assign cmd_err = r_cmd_err;
`else
    assign w_cmd_ok = 1'b1;
    assign cmd_err  = 1'b0;
`endif

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // Frame FSM: command decode, receive shift, word publish and MISO shift-out.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state    <= IDLE;
            r_phase    <= PH_SHIFT;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rd_flag  <= 1'b0;
            r_miso     <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            r_cmd_err  <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                // Deselect aborts whatever was in flight; rd_flag is kept.
                r_state <= IDLE;
                r_phase <= PH_SHIFT;
                r_cnt   <= '0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CHK_CMD;
                        r_phase <= PH_SHIFT;
                        r_cnt   <= '0;
                    end
                    CHK_CMD: begin
                        r_shift <= {r_shift[ADDR_SIZE:0], MOSI};
                        if (!MOSI)
                            r_state <= WRITE;
                        else if (r_rd_flag)
                            r_state <= READ_DATA;
                        else
                            r_state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        case (r_phase)
                            PH_SHIFT: begin
                                r_shift <= {r_shift[ADDR_SIZE:0], MOSI};
                                if (r_cnt == RX_LAST) begin
                                    r_cnt   <= '0;
                                    r_phase <= PH_VALID;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            PH_VALID: begin
                                if (w_cmd_ok) begin
                                    r_rx_data  <= r_shift;
                                    r_rx_valid <= 1'b1;
                                    if (r_state == READ_ADD)
                                        r_rd_flag <= 1'b1;
                                    r_phase <= (r_state == READ_DATA) ? PH_WAIT : PH_DONE;
                                end else begin
`ifdef SPI_SLAVE_CMD_CHECK_EN
                                    r_cmd_err <= 1'b1;
`endif
                                    r_phase <= PH_DONE;
                                end
                            end
                            PH_WAIT: begin
                                if (tx_valid) begin
                                    r_miso     <= tx_data[ADDR_SIZE-1];
                                    r_tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                                    r_cnt      <= '0;
                                    r_phase    <= PH_TX;
                                end
                            end
                            PH_TX: begin
                                // tx_valid is deliberately not looked at here.
                                if (r_cnt == TX_LAST) begin
                                    r_miso    <= 1'b0;
                                    r_rd_flag <= 1'b0;
                                    r_cnt     <= '0;
                                    r_phase   <= PH_DONE;
                                end else begin
                                    r_miso     <= r_tx_shift[ADDR_SIZE-1];
                                    r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                                    r_cnt      <= r_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_miso <= 1'b0;
                            end
                        endcase
                    end
                    default: begin
                        r_state <= IDLE;
                        r_phase <= PH_SHIFT;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning the address/data byte width; rx_data width is ADDR_SIZE+2.
REQ-002 SHALL have port clk, input, 1, the single clock for the block; the SPI serial clock equals clk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port SS_n, input, 1, active-low slave select that frames each transaction.
REQ-005 SHALL have port MOSI, input, 1, serial data in, MSB first.
REQ-006 SHALL have port MISO, output, 1, serial read data out, MSB first.
REQ-007 SHALL have port rx_data, output, 10, the received word: [9:8] command, [7:0] address or data.
REQ-008 SHALL have port rx_valid, output, 1, one-cycle strobe marking rx_data valid.
REQ-009 SHALL have port tx_data, input, 8, read data supplied by the memory.
REQ-010 SHALL have port tx_valid, input, 1, qualifies tx_data.
REQ-011 SHALL have port cmd_err, output, 1, sticky command-order error flag (see Configuration).

Function
REQ-012 SHALL implement the FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 SHALL move IDLE->CHK_CMD on the first clk edge with SS_n=0; otherwise stay in IDLE.
REQ-014 SHALL sample MOSI in CHK_CMD as rx bit 9, then move: MOSI=0 -> WRITE; MOSI=1 with rd_flag=0 -> READ_ADD; MOSI=1 with rd_flag=1 -> READ_DATA.
REQ-015 SHALL, in WRITE/READ_ADD/READ_DATA, shift 9 further MOSI bits (bits 8..0), one per clk, using a 4-bit counter.
REQ-016 SHALL drive rx_data with the 10 shifted bits and assert rx_valid for exactly one cycle, the cycle after bit 0 is sampled.
REQ-017 SHALL set rd_flag when a READ_ADD frame reaches rx_valid and clear it when a READ_DATA frame completes its MISO shift-out.
REQ-018 SHALL, in READ_DATA after rx_valid, wait for tx_valid=1, capture tx_data, then drive MISO with bits 7..0 on the following 8 cycles.
REQ-019 SHALL hold MISO at 0 whenever no read byte is being shifted out.
REQ-020 SHALL return to IDLE on the cycle after SS_n=1 from any state, clear the bit counter, not assert rx_valid, and leave rd_flag unchanged if the frame was incomplete.
REQ-021 SHALL ignore tx_valid outside the READ_DATA wait window, and SHALL ignore a second tx_valid while a byte is shifting out.
REQ-022 SHALL keep rx_data stable from the rx_valid cycle until the next rx_valid.

Reset
REQ-023 SHALL, on rst=1 at a clk edge: state=IDLE, rd_flag=0, counter=0, rx_data=0, rx_valid=0, MISO=0, cmd_err=0.
REQ-024 SHALL abort any frame, including a mid-shift MISO byte, when rst is asserted.

Configuration
REQ-025 SHALL use the macro SPI_SLAVE_CMD_CHECK_EN.
REQ-026 SHALL, with the macro defined, compare rx_data[9:8] against the state (WRITE: 00 or 01; READ_ADD: 10; READ_DATA: 11); on mismatch, suppress rx_valid and set cmd_err until reset.
REQ-027 SHALL, without the macro, forward every complete frame and tie cmd_err to 0.

Verification
REQ-028 Reset: assert rst mid-WRITE frame -> next cycle all outputs are 0 and state is IDLE.
REQ-029 Write address: SS_n=0, MOSI 00_1010_0101 -> rx_data=0x0A5, rx_valid for 1 cycle, 12 cycles after SS_n falls.
REQ-030 Read sequence: frame 10_0011_0011 (rd_flag set), then frame 11_xxxx_xxxx; memory returns tx_valid with tx_data=0xC3 -> MISO emits 1,1,0,0,0,0,1,1 and rd_flag clears.
REQ-031 Abort: SS_n rises after 5 bits -> no rx_valid, IDLE next cycle, and the next frame decodes correctly.
REQ-032 With SPI_SLAVE_CMD_CHECK_EN: READ_ADD frame carrying 11 -> no rx_valid and cmd_err=1; without the macro -> rx_valid=1 and cmd_err=0.
